// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder between NREQ clients.
// Operands are registered onto the adder, held for SETTLE cycles, and the sum is returned with the client ID.
module adder_share_arbiter #(
    parameter int WIDTH  = 13,
    parameter int NREQ   = 4,
    parameter int SETTLE = 2,
    parameter int IDW    = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ*WIDTH-1:0]   i_req_a,
    input  logic [NREQ*WIDTH-1:0]   i_req_b,
    output logic [NREQ-1:0]         o_req_ready,
    output logic [WIDTH-1:0]        o_add_term1,
    output logic [WIDTH-1:0]        o_add_term2,
    input  logic [WIDTH:0]          i_add_result,
    output logic                    o_rsp_valid,
    output logic [IDW-1:0]          o_rsp_id,
    output logic [WIDTH:0]          o_rsp_sum,
    input  logic                    i_rsp_ready,
    output logic                    o_busy
);

    localparam int CW = IDW + 2;
    localparam logic [CW-1:0] NREQ_C = CW'(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [IDW-1:0]   last_grant;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [CW-1:0]    cand;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Search starts one past the previous winner and wraps modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = CW'(last_grant) + CW'(i + 1);
            if (cand >= NREQ_C)
                cand = cand - NREQ_C;
            if (!grant_found && i_req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                sel_a = i_req_a[k*WIDTH +: WIDTH];
                sel_b = i_req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is forced low while reset is held, even though the state already reads IDLE.
    assign o_req_ready = (i_rst_n && state == ST_IDLE && grant_found) ?
                         (NREQ'(1) << grant_idx) : '0;
    assign o_busy      = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant_found)    state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt == '0)      state_nxt = ST_RESP;
            ST_RESP:   if (i_rsp_ready)    state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_add_term1 <= '0;
            o_add_term2 <= '0;
            o_rsp_id    <= '0;
            o_rsp_sum   <= '0;
            o_rsp_valid <= 1'b0;
            cnt         <= '0;
            last_grant  <= IDW'(NREQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        o_add_term1 <= sel_a;
                        o_add_term2 <= sel_b;
                        o_rsp_id    <= grant_idx;
                        last_grant  <= grant_idx;
                        cnt         <= 4'(SETTLE - 1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        o_rsp_sum   <= i_add_result;
                        o_rsp_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready)
                        o_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
